// File: rtl/parking_checkin.sv
// Entry stage: minute clock, slot occupancy map and entry stamps; grants a requested or lowest free slot.
// Grant/reject 1-6 cycles after the request edge; edges arriving outside IDLE are dropped, releases apply every cycle.
module parking_checkin #(
    parameter longint unsigned PRESCALE = 64'd6_000_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        car_in,
    input  logic [3:0]  req_slot,
    input  logic        car_out,
    input  logic [3:0]  out_slot,
    output logic [10:0] time_now,
    output logic [10:0] p1,
    output logic [10:0] p2,
    output logic [10:0] p3,
    output logic [10:0] p4,
    output logic [10:0] p5,
    output logic [10:0] p6,
    output logic [5:0]  occupied,
    output logic        full,
    output logic [3:0]  assigned_slot,
    output logic        assign_valid,
    output logic        reject
);
    localparam int              CW       = (PRESCALE > 64'd1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   PRE_LAST = CW'(PRESCALE - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_presc;
    logic [10:0]   r_time;
    logic [10:0]   r_stamp [6];
    logic [5:0]    r_occ;
    logic [3:0]    r_assigned;
    logic [3:0]    r_sel;
    logic [3:0]    r_idx;
    logic [3:0]    w_sel_nxt;
    logic [3:0]    w_idx_nxt;
    logic          r_valid;
    logic          r_reject;
    logic          r_car_in_q;
    logic          w_req;
    logic          w_full;
    logic          w_slot_busy;
    logic          w_grant;
    logic          w_reject;

    assign w_req  = car_in & ~r_car_in_q;
    assign w_full = &r_occ;

    // Out-of-range indices (explicit 7..15) read as busy so they fall into the reject path.
    always_comb begin
        w_slot_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (r_idx == 4'(k + 1)) w_slot_busy = r_occ[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (r_presc == PRE_LAST) begin
            r_presc <= '0;
            r_time  <= r_time + 11'd1;
        end else begin
            r_presc <= r_presc + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_idx_nxt   = r_idx;
        w_grant     = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_sel_nxt = req_slot;
                    if (req_slot != 4'd0) begin
                        w_idx_nxt   = req_slot;
                        w_state_nxt = S_SEARCH;
                    end else if (w_full) begin
                        w_reject = 1'b1;
                    end else begin
                        w_idx_nxt   = 4'd1;
                        w_state_nxt = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if (!w_slot_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_sel != 4'd0 || r_idx == 4'd6) begin
                    w_reject    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant is written after release so it wins on a shared slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_car_in_q <= 1'b0;
            r_sel      <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_reject   <= 1'b0;
            r_assigned <= '0;
            r_occ      <= '0;
            for (int k = 0; k < 6; k++) r_stamp[k] <= '0;
        end else begin
            r_car_in_q <= car_in;
            r_sel      <= w_sel_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_grant;
            r_reject   <= w_reject;
            if (w_grant) r_assigned <= r_idx;
            for (int k = 0; k < 6; k++) begin
                if (car_out && out_slot == 4'(k + 1)) begin
                    r_occ[k]   <= 1'b0;
                    r_stamp[k] <= '0;
                end
                if (w_grant && r_idx == 4'(k + 1)) begin
                    r_occ[k]   <= 1'b1;
                    r_stamp[k] <= r_time;
                end
            end
        end
    end

    assign time_now      = r_time;
    assign p1            = r_stamp[0];
    assign p2            = r_stamp[1];
    assign p3            = r_stamp[2];
    assign p4            = r_stamp[3];
    assign p5            = r_stamp[4];
    assign p6            = r_stamp[5];
    assign occupied      = r_occ;
    assign full          = w_full;
    assign assigned_slot = r_assigned;
    assign assign_valid  = r_valid;
    assign reject        = r_reject;
endmodule

// File: doc/parking_checkin.md
# parking_checkin

Entry-side stage of the parking controller. It owns the system minute clock, the slot occupancy map and the per-slot entry timestamps `p1`..`p6`, which feed the checkout/fee stage directly. On a car-arrival request it allocates either a requested slot or the lowest free slot and stamps that slot with the current time. It frees a slot when checkout signals a departure.

## Interface
- `PRESCALE`, default 6_000_000_000 (60 s at 100 MHz; the bench overrides it): `clk` cycles per time tick. Counter width is `$clog2(PRESCALE)`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  **synchronous, active-low** reset.
- `car_in`  in  1  arrival request level, synchronous to `clk`; a request is its rising edge.
- `req_slot`  in  4  requested slot. 0 = auto-assign; 1–6 = explicit slot; 7–15 = invalid.
- `car_out`  in  1  departure strobe from checkout, sampled every cycle.
- `out_slot`  in  4  slot being released, 1–6. Other values are ignored.
- `time_now`  out  11  current time in minutes; wraps 2047→0.
- `p1`..`p6`  out  11 each  entry timestamp of each slot.
- `occupied`  out  6  bit k-1 set means slot k is occupied.
- `full`  out  1  equals `&occupied` (combinational).
- `assigned_slot`  out  4  slot granted by the last successful request.
- `assign_valid`  out  1  one-cycle pulse on grant.
- `reject`  out  1  one-cycle pulse on refusal.

## Operation
- Time base:
  - The prescaler counts 0..PRESCALE-1.
  - On its terminal count, `time_now` increments and the prescaler returns to 0.
  - Wrap from 2047 to 0 is plain modulo; no flag is raised.
- Edge detect: register `car_in_q` every cycle. `req = car_in & ~car_in_q`.
- FSM states: IDLE, SEARCH, DONE.
  - **IDLE**
    - If `req` is set: latch `req_slot` into `sel`.
    - Auto mode (`sel` = 0) with `full` set → `reject` is set and the state stays IDLE.
    - Auto mode otherwise → scan index `idx` = 1, go to SEARCH.
    - Explicit mode → `idx` = `sel`, go to SEARCH.
  - **SEARCH** checks slot `idx` against the pre-edge `occupied`, one slot per cycle.
    - Explicit slot 7–15, or explicit slot occupied → `reject` is set, go to DONE.
    - Slot free → `p[idx]` = `time_now` (pre-tick value), `occupied[idx]` = 1, `assigned_slot` = `idx`, `assign_valid` = 1, go to DONE.
    - Auto mode with the slot occupied → `idx` increments. If `idx` was 6, `reject` is set and the state goes to DONE. This covers slots freed and refilled mid-scan.
  - **DONE** lasts one cycle, then returns to IDLE. Edges arriving in SEARCH or DONE are dropped; `car_in_q` keeps tracking.
- Release:
  - When `car_out` is set and `out_slot` is 1–6, slot k gets `occupied[k]` = 0 and `p[k]` = 0, in any FSM state.
  - Release of an already-free slot is a no-op.
- Simultaneous grant and release on the same slot in the same edge: grant wins. Grant requires the slot to be free before the edge, so the release was a no-op anyway.
- Release of slot j while SEARCH is checking slot k≠j: both take effect.
- `assign_valid` and `reject` are never set together.

## Timing
- Reset (`rst_n` = 0 at an edge) clears:
  - `time_now`, the prescaler, `p1`..`p6`, `occupied` and `assigned_slot` to 0;
  - `assign_valid`, `reject` and `car_in_q` to 0;
  - the FSM to IDLE.
- Reset mid-SEARCH aborts the request with no pulse.
- Reset overrides `car_out`.
- Let E0 be the edge that sees `req`.
  - Explicit request: grant or reject is applied at E1 and visible in the cycle after E1.
  - Auto request, first free slot k: grant at Ek.
  - Auto request, all slots full mid-scan: reject at E6.
  - Auto request, full at E0: reject applied at E0.
- Minimum spacing between accepted requests: 3 cycles for explicit mode. A new edge is accepted only in IDLE.
- All outputs except `full` are registered.

## Test plan
- Reset, then explicit requests:
  - Hold `rst_n` = 0 for 3 cycles → all outputs are 0.
  - `req_slot` = 3, `car_in` 0→1 → `assign_valid` pulses 2 cycles later with `assigned_slot` = 3, `occupied` = 6'b000100, `p3` = `time_now`.
  - Repeat `req_slot` = 3 → `reject` pulses and the state is unchanged.
  - `req_slot` = 9 → `reject` pulses.
- Auto fill, with PRESCALE = 4:
  - Six auto requests, `time_now` advancing → slots 1..6 are granted in order with distinct stamps and `full` = 1.
  - Seventh request → `reject` is set the cycle after the edge.
- Release and refill:
  - Fill all slots; `car_out` with `out_slot` = 4 → `p4` = 0 and `occupied[3]` = 0.
  - Next auto request → `assigned_slot` = 4 after 4 scan cycles.
- Collisions:
  - Auto scan under way; release slot 2 at the edge where `idx` = 2 is checked → slot 2 is seen occupied and the scan continues. The release still clears slot 2.
  - A second `car_in` edge during SEARCH is ignored: exactly one pulse results.
- Wrap and reset:
  - Force `time_now` = 2047, advance one tick → `time_now` = 0.
  - A grant at that boundary edge stores 2047.
  - Assert `rst_n` = 0 mid-scan → no pulse and all state clears.
